// File: rtl/linear_1d_pkg.sv
// rtl/linear_1d_pkg.sv - shared state encoding and width defaults for the go/done controller
package linear_1d_pkg;

  localparam int CNT_WIDTH_DEF = 32;
  localparam int TO_WIDTH_DEF  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_BUSY  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

endpackage

// File: rtl/linear_1d_go_done_edge.sv
// rtl/linear_1d_go_done_edge.sv - go level delay register and rising-edge detect (linear_1d_edge)
module linear_1d_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic go_sync,
  output logic go_rise
);

  logic go_d;

  // Resetting high means a go level already asserted at reset release is not an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) go_d <= 1'b1;
    else          go_d <= go_sync;
  end

  assign go_rise = go_sync & ~go_d;

endmodule

// File: rtl/linear_1d_go_done.sv
// rtl/linear_1d_go_done.sv - go/done handshake controller; optional watchdog under LINEAR_1D_TIMEOUT_EN
module linear_1d_go_done
  import linear_1d_pkg::*;
#(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int TO_WIDTH  = TO_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 go_sync,
  output logic                 core_start,
  input  logic                 core_done,
  output logic                 busy,
  output logic                 done_level,
  output logic [CNT_WIDTH-1:0] run_cycles,
  input  logic [TO_WIDTH-1:0]  timeout_limit,
  output logic                 timeout_err
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state;
  logic                 go_rise;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;

  linear_1d_edge u_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .go_sync (go_sync),
    .go_rise (go_rise)
  );

  // cnt holds the run length including the current cycle; it sticks at all-ones.
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_ONE;

`ifdef LINEAR_1D_TIMEOUT_EN
  localparam logic [TO_WIDTH-1:0] TO_ONE = {{(TO_WIDTH-1){1'b0}}, 1'b1};
  logic [TO_WIDTH-1:0] wd_cnt;
  logic                wd_expire;

  assign wd_expire = (timeout_limit != '0) && (wd_cnt == timeout_limit);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_limit;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      core_start  <= 1'b0;
      busy        <= 1'b0;
      done_level  <= 1'b0;
      run_cycles  <= '0;
      timeout_err <= 1'b0;
      cnt         <= '0;
`ifdef LINEAR_1D_TIMEOUT_EN
      wd_cnt      <= '0;
`endif
    end else begin
      core_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go_rise) begin
            state       <= ST_START;
            core_start  <= 1'b1;
            busy        <= 1'b1;
            cnt         <= CNT_ONE;
            timeout_err <= 1'b0;
`ifdef LINEAR_1D_TIMEOUT_EN
            wd_cnt      <= '0;
`endif
          end
        end
        // An engine pulse coincident with the start pulse is stale and deliberately dropped.
        ST_START: begin
          state <= ST_BUSY;
          cnt   <= cnt_inc;
        end
        ST_BUSY: begin
          if (core_done) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            done_level <= 1'b1;
            run_cycles <= cnt;
`ifdef LINEAR_1D_TIMEOUT_EN
          end else if (wd_expire) begin
            state       <= ST_ABORT;
            busy        <= 1'b0;
            done_level  <= 1'b1;
            run_cycles  <= cnt;
            timeout_err <= 1'b1;
`endif
          end else begin
            cnt <= cnt_inc;
`ifdef LINEAR_1D_TIMEOUT_EN
            wd_cnt <= wd_cnt + TO_ONE;
`endif
          end
        end
        ST_DONE, ST_ABORT: begin
          if (!go_sync) begin
            state      <= ST_IDLE;
            done_level <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          done_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_linear_1d_go_done.sv
// tb/tb_linear_1d_go_done.sv - self-checking bench for linear_1d_go_done (LINEAR_1D_TIMEOUT_EN aware)
module tb_linear_1d_go_done;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        go_sync;
  logic        core_start;
  logic        core_done;
  logic        busy;
  logic        done_level;
  logic [31:0] run_cycles;
  logic [15:0] timeout_limit;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  // Held-output expectations: last latched run length and the sticky error flag.
  logic [31:0] last_rc = 32'd0;
  logic        last_to = 1'b0;

  always #5 clk = ~clk;

  linear_1d_go_done dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .go_sync       (go_sync),
    .core_start    (core_start),
    .core_done     (core_done),
    .busy          (busy),
    .done_level    (done_level),
    .run_cycles    (run_cycles),
    .timeout_limit (timeout_limit),
    .timeout_err   (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks one cycle's outputs mid-cycle, then advances to just after the next edge.
  task automatic cyc(input logic e_start, input logic e_busy, input logic e_done,
                     input logic [31:0] e_rc, input logic e_to);
    @(negedge clk);
    chk("core_start", {31'd0, core_start}, {31'd0, e_start});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("done_level", {31'd0, done_level}, {31'd0, e_done});
    chk("run_cycles", run_cycles, e_rc);
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, e_to});
    @(posedge clk);
    #1;
  endtask

  // One request: go rises in relative cycle 0, START is cycle 1, core_done lands in cycle lat,
  // so run_cycles = lat. Without early drop, done_level is high for hold cycles.
  task automatic do_run(input int lat, input int hold, input bit early, input bit extra,
                        input int limit);
    timeout_limit = 16'(limit);
    go_sync   = 1'b1;
    core_done = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, last_rc, last_to);
    if (extra) core_done = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, last_rc, 1'b0);
    last_to = 1'b0;
    for (int i = 2; i <= lat; i++) begin
      core_done = (i == lat);
      if (early && i == 2) go_sync = 1'b0;
      if (extra && i == 2) go_sync = 1'b0;
      if (extra && i == 3) go_sync = 1'b1;
      cyc(1'b0, 1'b1, 1'b0, last_rc, last_to);
    end
    core_done = 1'b0;
    last_rc   = 32'(lat);
    if (early) begin
      cyc(1'b0, 1'b0, 1'b1, last_rc, last_to);
    end else begin
      for (int j = 1; j <= hold; j++) begin
        go_sync = (j < hold);
        cyc(1'b0, 1'b0, 1'b1, last_rc, last_to);
      end
    end
    cyc(1'b0, 1'b0, 1'b0, last_rc, last_to);
  endtask

`ifdef LINEAR_1D_TIMEOUT_EN
  // Expiry is in the BUSY cycle after limit full BUSY cycles, i.e. relative cycle limit+2.
  task automatic do_abort(input int limit);
    timeout_limit = 16'(limit);
    go_sync   = 1'b1;
    core_done = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, last_rc, last_to);
    cyc(1'b1, 1'b1, 1'b0, last_rc, 1'b0);
    last_to = 1'b0;
    for (int i = 2; i <= limit + 2; i++) cyc(1'b0, 1'b1, 1'b0, last_rc, last_to);
    last_rc = 32'(limit + 2);
    last_to = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, last_rc, last_to);
    go_sync = 1'b0;
    cyc(1'b0, 1'b0, 1'b1, last_rc, last_to);
    core_done = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, last_rc, last_to);
    core_done = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, last_rc, last_to);
    timeout_limit = 16'd0;
  endtask
`endif

  initial begin
    int lat, hold, lim;
    bit early, extra;
    reset_n       = 1'b0;
    go_sync       = 1'b1;
    core_done     = 1'b0;
    timeout_limit = 16'd0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // go held high across reset release must not start a run.
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    go_sync = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    do_run(10, 5, 1'b0, 1'b0, 0);
    do_run(2, 1, 1'b0, 1'b0, 0);
    do_run(7, 1, 1'b1, 1'b0, 0);
    do_run(6, 2, 1'b0, 1'b1, 0);
    do_run(10, 2, 1'b0, 1'b0, 8);

`ifdef LINEAR_1D_TIMEOUT_EN
    do_abort(8);
    do_run(4, 2, 1'b0, 1'b0, 0);
    do_abort(1);
`else
    do_run(15, 2, 1'b0, 1'b0, 8);
`endif

    for (int n = 0; n < 25; n++) begin
      lat   = int'($urandom_range(2, 12));
      hold  = int'($urandom_range(1, 5));
      early = 1'($urandom_range(0, 1));
      extra = (!early && lat >= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef LINEAR_1D_TIMEOUT_EN
      lim = ($urandom_range(0, 1) == 0) ? 0 : lat - 2 + int'($urandom_range(0, 3));
`else
      lim = int'($urandom_range(1, 3));
`endif
      do_run(lat, hold, early, extra, lim);
    end

    // Reset mid-run, then a late engine pulse that must be ignored.
    timeout_limit = 16'd0;
    go_sync = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, last_rc, last_to);
    cyc(1'b1, 1'b1, 1'b0, last_rc, 1'b0);
    last_to = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, last_rc, last_to);
    reset_n = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, last_rc, last_to);
    reset_n   = 1'b1;
    core_done = 1'b1;
    last_rc   = 32'd0;
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    core_done = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    go_sync = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    do_run(3, 1, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/linear_1d_go_done.md
# linear_1d_go_done

Go/done handshake controller for the linear_1d_many core, sitting directly downstream of the go-signal synchronizer in the core clock domain. It turns the synchronized `go` level into a single-cycle start pulse for the linear engine and tracks the run. It returns a four-phase `done` level for synchronization back to the requester, and reports run length and, optionally, a watchdog timeout.

## Interface
- `CNT_WIDTH`, 32: width of the run-length counter.
- `TO_WIDTH`, 16: width of the timeout limit and watchdog counter.

- `clk`  in  1  core clock.
- `reset_n`  in  1  reset; synchronous, active-low.
- `go_sync`  in  1  requester go level, already synchronized into `clk`.
- `core_start`  out  1  one-cycle start pulse to the linear engine.
- `core_done`  in  1  one-cycle completion pulse from the engine.
- `busy`  out  1  high from the `core_start` cycle until completion.
- `done_level`  out  1  four-phase done level, synchronized back to the requester.
- `run_cycles`  out  CNT_WIDTH  length of the last run, latched.
- `timeout_limit`  in  TO_WIDTH  watchdog limit in cycles; 0 disables the watchdog.
- `timeout_err`  out  1  sticky flag: last run aborted by the watchdog.

## Operation
- States:
  - IDLE: waiting for a request.
  - START: one cycle; `core_start`=1, `busy`=1.
  - BUSY: waiting for `core_done`.
  - DONE: `done_level`=1, waiting for `go_sync` low.
  - ABORT: like DONE; exists only with the watchdog compiled in.
- `go_d` register samples `go_sync` every cycle. Rising edge = `go_sync & ~go_d`.
- Rising edges are honoured only in IDLE and are ignored in all other states.
- Transitions:
  - IDLE→START on rising edge.
  - START→BUSY unconditionally. `core_done` in the START cycle is ignored.
  - BUSY→DONE when `core_done`=1.
  - DONE→IDLE when `go_sync`=0.
  - BUSY→ABORT on watchdog expiry.
  - ABORT→IDLE when `go_sync`=0.
- `go_sync` falling during START/BUSY does not abort the run. The run completes. DONE then holds `done_level` for exactly one cycle and returns to IDLE.
- `run_cycles`:
  - Counts from the START cycle through the `core_done` cycle inclusive, so the minimum value is 2.
  - Saturates at all-ones.
  - Updates only on entry to DONE or ABORT and holds otherwise.
- `timeout_err` is cleared on entry to START and set on entry to ABORT.

## Timing
- Reset:
  - All outputs are 0 and the state is IDLE.
  - `go_d` resets to 1, so a `go_sync` that is high at reset release does not start a run. It must go low, then high again.
- Edge sampled in cycle n → `core_start`=1 and `busy`=1 in cycle n+1, for exactly one cycle of `core_start`.
- `core_done` in cycle m (BUSY) → cycle m+1: `done_level`=1, `busy`=0, `run_cycles` valid.
- `go_sync` low sampled in cycle k (DONE/ABORT) → `done_level`=0 in cycle k+1.
- All outputs are registered.
- `reset_n` low mid-run returns the block to IDLE on the next edge. An engine pulse arriving after reset is ignored.

## Configuration
- `LINEAR_1D_TIMEOUT_EN` defined:
  - A TO_WIDTH watchdog counter clears at START and increments each BUSY cycle.
  - When it equals a nonzero `timeout_limit` without `core_done`, the block moves BUSY→ABORT and `done_level`=1 on the next cycle.
  - `core_done` in the expiry cycle wins: the block goes to DONE with no error.
- `LINEAR_1D_TIMEOUT_EN` undefined: no watchdog and no ABORT state. `timeout_limit` is ignored and `timeout_err` is tied to 0. The ports remain present.

## Structure
- Shared package/header `linear_1d_pkg`: state encoding constants, and defaults for CNT_WIDTH and TO_WIDTH.
- One natural sub-module, `linear_1d_edge`: the `go_d` register and rising-edge detect, with reset value 1.

## Test plan
- Basic run:
  - Stimulus: `go_sync` rises at cycle 10, `core_done` at cycle 20, `go_sync` falls at cycle 25.
  - Required response: `core_start` only at cycle 11; `busy` 11–20; `done_level` 21–25; `run_cycles`=10.
- High at reset: `go_sync` held high through reset release → no `core_start` until `go_sync` toggles low then high.
- Early go drop: `go_sync` falls while BUSY; `core_done` 5 cycles later → `done_level` high for one cycle only, then IDLE.
- Ignored requests: second rising edge during BUSY, and `core_done` in the START cycle → both ignored; exactly one `core_start`.
- Watchdog (macro on):
  - `timeout_limit`=8 with no `core_done` → ABORT, `timeout_err`=1, `done_level`=1. The next run clears `timeout_err`.
  - `core_done` in the expiry cycle → DONE with `timeout_err`=0.
- Mid-run reset: `reset_n` low for 1 cycle in BUSY → all outputs 0 next cycle; a subsequent `core_done` is ignored.
